// File: rtl/mac_pkg.sv
// Shared types and width helpers for the MAC accumulator slice.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Accumulator is the full product width plus guard bits for headroom.
  function automatic int acc_width(input int n, input int g);
    return 2 * n + g;
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the product source, the accumulator and the result consumer.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int N     = 64,
  parameter int G     = 8,
  parameter int CNT_W = 16
);
  localparam int ACC_W = acc_width(N, G);

  logic               start;
  logic [CNT_W-1:0]   len;
  logic               in_valid;
  logic               in_ready;
  logic [2*N-1:0]     in_prod;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_acc;
  logic               busy;
  logic               ovf;

  modport master (
    output start, len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_acc, busy, ovf
  );

  modport slave (
    input  start, len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_acc, busy, ovf
  );

endinterface

// File: rtl/sat_adder.sv
// Combinational W-bit signed add with overflow flag; zero latency, no backpressure.
// Build option MAC_ACCUMULATOR_SATURATE_EN clamps on overflow instead of wrapping.
module sat_adder #(
  parameter int W = 136
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] raw;

  assign raw = a + b;
  // Overflow only possible when both operands share a sign and the result flips it.
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  assign sum = ovf ? (a[W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Sums a programmed count of signed products; result valid 1 cycle after last accept, held until out_ready.
// Products only accepted in ACCUM; MAC_ACCUMULATOR_SATURATE_EN selects clamping instead of wrap.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N     = 64,
  parameter int G     = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  mac_accumulator_if.slave bus
);

  localparam int ACC_W = acc_width(N, G);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   add_sum;
  logic [ACC_W-1:0]   prod_ext;
  logic [CNT_W-1:0]   remaining;
  logic               ovf_q;
  logic               add_ovf;
  logic               in_ready_c;
  logic               out_valid_c;
  logic               busy_c;
  logic               in_hs;

  assign prod_ext = {{G{bus.in_prod[2*N-1]}}, bus.in_prod};
  assign in_hs    = bus.in_valid & in_ready_c;

  sat_adder #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b1;
        if (in_hs && (remaining == CNT_W'(1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: a new start clears the sum and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      remaining <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc       <= '0;
            ovf_q     <= 1'b0;
            remaining <= bus.len;
          end
        end
        ACCUM: begin
          if (in_hs) begin
            acc       <= add_sum;
            remaining <= remaining - CNT_W'(1);
            ovf_q     <= ovf_q | add_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_acc   = acc;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized self-checking bench for mac_accumulator (N=8, G=1, ACC_W=17) against an arithmetic reference model.
module tb_mac_accumulator;

  localparam int N     = 8;
  localparam int G     = 1;
  localparam int CNT_W = 16;
  localparam int ACC_W = 2 * N + G;
  localparam int PW    = 2 * N;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));
  localparam longint ACC_MOD = longint'(1) <<< ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int prods[$];

  mac_accumulator_if #(.N(N), .G(G), .CNT_W(CNT_W)) bus ();

  mac_accumulator #(.N(N), .G(G), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer sum, with overflow judged against the signed ACC_W range.
  task automatic model(input int n, output logic [ACC_W-1:0] e_acc, output bit e_ovf);
    longint a;
    longint t;
    a = 0;
    e_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = a + longint'(prods[i]);
      if (t > ACC_MAX || t < ACC_MIN) begin
        e_ovf = 1'b1;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        t = (t > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
        t = (t > ACC_MAX) ? t - ACC_MOD : t + ACC_MOD;
`endif
      end
      a = t;
    end
    e_acc = a[ACC_W-1:0];
  endtask

  task automatic rand_prods(input int n);
    logic signed [PW-1:0] r;
    prods.delete();
    for (int i = 0; i < n; i++) begin
      r = PW'($urandom);
      prods.push_back(int'(r));
    end
  endtask

  // Starts a run of n products from prods[], optionally with gaps or a stray start mid-run.
  // Returns accepted count and edges from the last accepting edge to out_valid (1 expected).
  task automatic run_acc(input int n, input bit gaps, input bit poke_start,
                         output int accepted, output int lat);
    int idx;
    int cyc;
    bus.start = 1'b1;
    bus.len   = CNT_W'(n);
    tick();
    bus.start = 1'b0;
    accepted = 0;
    idx = 0;
    cyc = 0;
    while (accepted < n && cyc < 1000) begin
      if (poke_start && (cyc == 1 || cyc == 2)) begin
        bus.start = 1'b1;
        bus.len   = CNT_W'(1);
      end else begin
        bus.start = 1'b0;
      end
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_prod  = PW'(prods[idx]);
      if (bus.in_valid && bus.in_ready) begin
        accepted++;
        idx++;
      end
      tick();
      cyc++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_prod = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.out_acc !== '0) $display("FAIL reset_out_acc got=%0d exp=0", bus.out_acc); else n_pass++;
    n_checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", bus.ovf); else n_pass++;
  endtask

  task automatic test_basic();
    int acc_n, lat;
    logic [ACC_W-1:0] e_acc;
    bit e_ovf;
    prods = '{100, -50, 7};
    model(3, e_acc, e_ovf);
    run_acc(3, 1'b0, 1'b0, acc_n, lat);
    n_checks++; if (lat !== 1) $display("FAIL basic_latency got=%0d exp=1", lat); else n_pass++;
    n_checks++; if (bus.out_acc !== e_acc) $display("FAIL basic_out_acc got=%0d exp=%0d", bus.out_acc, e_acc); else n_pass++;
    n_checks++; if (bus.ovf !== e_ovf) $display("FAIL basic_ovf got=%b exp=%b", bus.ovf, e_ovf); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_done got=%b exp=1", bus.busy); else n_pass++;
    accept_out();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL basic_idle_after_accept out_valid=%b busy=%b exp=0/0", bus.out_valid, bus.busy); else n_pass++;
  endtask

  task automatic test_len_zero();
    bit seen_ready;
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(1234);
    seen_ready = bus.in_ready;
    bus.start = 1'b1;
    bus.len   = '0;
    tick();
    bus.start = 1'b0;
    seen_ready |= bus.in_ready;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL len0_out_valid got=%b exp=1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_acc !== '0) $display("FAIL len0_out_acc got=%0d exp=0", bus.out_acc); else n_pass++;
    tick();
    seen_ready |= bus.in_ready;
    n_checks++; if (seen_ready !== 1'b0) $display("FAIL len0_in_ready got=%b exp=0", seen_ready); else n_pass++;
    n_checks++; if (bus.out_acc !== '0) $display("FAIL len0_unconsumed got=%0d exp=0", bus.out_acc); else n_pass++;
    bus.in_valid = 1'b0;
    accept_out();
  endtask

  task automatic test_overflow();
    int acc_n, lat;
    logic [ACC_W-1:0] e_acc;
    bit e_ovf;
    prods = '{16384, 16384, 16384, 16384};
    model(4, e_acc, e_ovf);
    run_acc(4, 1'b0, 1'b0, acc_n, lat);
    n_checks++; if (lat !== 1) $display("FAIL ovf_latency got=%0d exp=1", lat); else n_pass++;
    n_checks++; if (bus.out_acc !== e_acc) $display("FAIL ovf_out_acc got=%0d exp=%0d", $signed(bus.out_acc), $signed(e_acc)); else n_pass++;
    n_checks++; if (bus.ovf !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", bus.ovf); else n_pass++;
    accept_out();
  endtask

  task automatic test_gaps_hold();
    int acc_n, lat;
    logic [ACC_W-1:0] e_acc;
    bit e_ovf;
    rand_prods(2);
    model(2, e_acc, e_ovf);
    run_acc(2, 1'b1, 1'b0, acc_n, lat);
    n_checks++; if (lat !== 1) $display("FAIL gaps_latency got=%0d exp=1", lat); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", i, bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_acc !== e_acc) $display("FAIL hold_out_acc cyc=%0d got=%0d exp=%0d", i, bus.out_acc, e_acc); else n_pass++;
      tick();
    end
    n_checks++; if (bus.ovf !== e_ovf) $display("FAIL gaps_ovf got=%b exp=%b", bus.ovf, e_ovf); else n_pass++;
    accept_out();
    n_checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL gaps_idle busy=%b out_valid=%b exp=0/0", bus.busy, bus.out_valid); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int acc_n, lat;
    logic [ACC_W-1:0] e_acc;
    bit e_ovf;
    bit seen_ready;
    rand_prods(8);
    model(5, e_acc, e_ovf);
    run_acc(5, 1'b0, 1'b1, acc_n, lat);
    n_checks++; if (lat !== 1) $display("FAIL restart_latency got=%0d exp=1", lat); else n_pass++;
    n_checks++; if (bus.out_acc !== e_acc) $display("FAIL restart_out_acc got=%0d exp=%0d", bus.out_acc, e_acc); else n_pass++;
    seen_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(prods[5]);
    for (int i = 0; i < 3; i++) begin
      seen_ready |= bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (seen_ready !== 1'b0) $display("FAIL done_in_ready got=%b exp=0", seen_ready); else n_pass++;
    n_checks++; if (bus.out_acc !== e_acc) $display("FAIL done_no_consume got=%0d exp=%0d", bus.out_acc, e_acc); else n_pass++;
    accept_out();
  endtask

  task automatic test_reset_mid();
    int acc_n, lat;
    bus.start = 1'b1;
    bus.len   = CNT_W'(4);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(-30000);
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.out_acc !== '0) $display("FAIL midrst_out_acc got=%0d exp=0", bus.out_acc); else n_pass++;
    n_checks++; if (bus.ovf !== 1'b0) $display("FAIL midrst_ovf got=%b exp=0", bus.ovf); else n_pass++;
    prods = '{42};
    run_acc(1, 1'b0, 1'b0, acc_n, lat);
    n_checks++; if (lat !== 1) $display("FAIL fresh_latency got=%0d exp=1", lat); else n_pass++;
    n_checks++; if (bus.out_acc !== ACC_W'(42)) $display("FAIL fresh_out_acc got=%0d exp=42", bus.out_acc); else n_pass++;
    accept_out();
  endtask

  task automatic test_back_to_back();
    int acc_n, lat, n;
    logic [ACC_W-1:0] e_acc;
    bit e_ovf;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 9);
      rand_prods(n);
      model(n, e_acc, e_ovf);
      run_acc(n, 1'(r % 2), 1'b0, acc_n, lat);
      n_checks++; if (lat !== 1) $display("FAIL b2b_latency run=%0d got=%0d exp=1", r, lat); else n_pass++;
      n_checks++; if (bus.out_acc !== e_acc) $display("FAIL b2b_out_acc run=%0d got=%0d exp=%0d", r, bus.out_acc, e_acc); else n_pass++;
      n_checks++; if (bus.ovf !== e_ovf) $display("FAIL b2b_ovf run=%0d got=%b exp=%b", r, bus.ovf, e_ovf); else n_pass++;
      accept_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_overflow();
    test_gaps_hold();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
